// File: rtl/mux_scan_if.sv
// mux_scan_if: control, data and status bundle for the mux_scan channel scanner.
interface mux_scan_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int IW = $clog2(CHANNELS);
    logic                      en;
    logic                      manual;
    logic [IW-1:0]             sel;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [WIDTH-1:0]          dout;
    logic [CHANNELS-1:0]       ch_onehot;
    logic [IW-1:0]             ch_idx;
    logic                      wrap;
    modport master (output en, manual, sel, din, input dout, ch_onehot, ch_idx, wrap);
    modport slave  (input en, manual, sel, din, output dout, ch_onehot, ch_idx, wrap);
endinterface

// File: rtl/mux_scan.sv
// mux_scan: prescaled auto/manual channel scanner with registered data select.
// Optional MUX_SCAN_BLANK_EN blanks the first auto-scan cycle of each slot.
module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 4
) (
    input logic     clk,
    input logic     rst_n,
    mux_scan_if.slave bus
);
    localparam int IW = $clog2(CHANNELS);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [IW-1:0] LAST  = IW'(CHANNELS - 1);
    localparam logic [IW:0]   NCH   = (IW + 1)'(CHANNELS);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
    logic [PW-1:0] presc, presc_n;
    logic [IW-1:0] idx_n;
    logic          wrap_n, blank, last;
    // With DIV=1, PLAST is 0 so the prescaler stays tied at 0 and every enabled cycle advances.
    assign last = presc == PLAST;
    always_comb begin
        presc_n = presc;
        idx_n   = bus.ch_idx;
        wrap_n  = 1'b0;
        if (bus.manual) begin
            presc_n = '0;
            idx_n   = ({1'b0, bus.sel} < NCH) ? bus.sel : bus.ch_idx;
        end else if (bus.en) begin
            presc_n = last ? '0 : presc + PW'(1);
            idx_n   = !last ? bus.ch_idx : (bus.ch_idx == LAST) ? '0 : bus.ch_idx + IW'(1);
            wrap_n  = last && bus.ch_idx == LAST;
        end
    end
`ifdef MUX_SCAN_BLANK_EN
    assign blank = !bus.manual && presc_n == '0;
`else
    assign blank = 1'b0;
`endif
    // Outputs are loaded from next-state values so dout, ch_onehot and ch_idx stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            bus.ch_idx    <= '0;
            bus.ch_onehot <= CHANNELS'(1);
            bus.dout      <= '0;
            bus.wrap      <= 1'b0;
        end else begin
            presc         <= presc_n;
            bus.ch_idx    <= idx_n;
            bus.ch_onehot <= blank ? '0 : CHANNELS'(1) << idx_n;
            bus.dout      <= blank ? '0 : bus.din[idx_n*WIDTH +: WIDTH];
            bus.wrap      <= wrap_n;
        end
    end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed checks of scan, hold, manual, async reset, blanking and DIV=1.
module tb_mux_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;

    mux_scan_if #(.WIDTH(4), .CHANNELS(4)) b0();
    mux_scan_if #(.WIDTH(4), .CHANNELS(3)) b1();
    mux_scan_if #(.WIDTH(4), .CHANNELS(2)) b2();
    mux_scan #(.WIDTH(4), .CHANNELS(4), .DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_scan #(.WIDTH(4), .CHANNELS(3), .DIV(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux_scan #(.WIDTH(4), .CHANNELS(2), .DIV(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    function automatic logic [3:0] m_dout(input int idx, input int pr, input logic [15:0] d);
        logic [3:0] r;
        r = d[idx*4 +: 4];
`ifdef MUX_SCAN_BLANK_EN
        if (pr == 0) r = '0;
`endif
        return r;
    endfunction

    function automatic logic [3:0] m_oh(input int idx, input int pr);
        logic [3:0] r;
        r = 4'b0001 << idx;
`ifdef MUX_SCAN_BLANK_EN
        if (pr == 0) r = '0;
`endif
        return r;
    endfunction

    task automatic test_reset();
        b0.en = 0; b0.manual = 0; b0.sel = '0; b0.din = 16'h4321;
        b1.en = 0; b1.manual = 0; b1.sel = '0; b1.din = 12'h321;
        b2.en = 0; b2.manual = 0; b2.sel = '0; b2.din = 8'h21;
        #1 rst_n = 0;
        #2;
        n_cmp++; if (b0.ch_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", b0.ch_idx); end
        n_cmp++; if (b0.ch_onehot !== 4'b0001) begin n_err++; $display("FAIL reset_onehot got %b want 0001", b0.ch_onehot); end
        n_cmp++; if (b0.dout !== 4'h0) begin n_err++; $display("FAIL reset_dout got %h want 0", b0.dout); end
        n_cmp++; if (b0.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", b0.wrap); end
        n_cmp++; if (b2.ch_onehot !== 2'b01) begin n_err++; $display("FAIL reset_onehot2 got %b want 01", b2.ch_onehot); end
        repeat (2) @(negedge clk);
        b0.en = 1;
        rst_n = 1;
    endtask

    task automatic test_scan();
        for (int c = 1; c <= 17; c++) begin
            logic [1:0] ei;
            logic [3:0] ed, eo;
            logic ew;
            @(posedge clk); #1;
            ei = 2'((c / 4) % 4);
            ed = m_dout(int'(ei), c % 4, 16'h4321);
            eo = m_oh(int'(ei), c % 4);
            ew = (c % 16) == 0;
            n_cmp++; if (b0.ch_idx !== ei) begin n_err++; $display("FAIL scan_idx c=%0d got %0d want %0d", c, b0.ch_idx, ei); end
            n_cmp++; if (b0.dout !== ed) begin n_err++; $display("FAIL scan_dout c=%0d got %h want %h", c, b0.dout, ed); end
            n_cmp++; if (b0.ch_onehot !== eo) begin n_err++; $display("FAIL scan_onehot c=%0d got %b want %b", c, b0.ch_onehot, eo); end
            n_cmp++; if (b0.wrap !== ew) begin n_err++; $display("FAIL scan_wrap c=%0d got %b want %b", c, b0.wrap, ew); end
        end
    endtask

    task automatic test_hold();
        @(negedge clk) b0.en = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (b0.ch_idx !== 2'd0) begin n_err++; $display("FAIL hold_idx i=%0d got %0d want 0", i, b0.ch_idx); end
            n_cmp++; if (b0.dout !== 4'h1) begin n_err++; $display("FAIL hold_dout i=%0d got %h want 1", i, b0.dout); end
            n_cmp++; if (b0.wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap i=%0d got %b want 0", i, b0.wrap); end
        end
        @(negedge clk) b0.en = 1;
        for (int j = 1; j <= 3; j++) begin
            logic [1:0] ei;
            logic [3:0] ed;
            @(posedge clk); #1;
            ei = (j == 3) ? 2'd1 : 2'd0;
            ed = m_dout(int'(ei), (1 + j) % 4, 16'h4321);
            n_cmp++; if (b0.ch_idx !== ei) begin n_err++; $display("FAIL resume_idx j=%0d got %0d want %0d", j, b0.ch_idx, ei); end
            n_cmp++; if (b0.dout !== ed) begin n_err++; $display("FAIL resume_dout j=%0d got %h want %h", j, b0.dout, ed); end
        end
    endtask

    task automatic test_manual();
        @(negedge clk);
        b0.manual = 1; b0.sel = 2'd2;
        b1.manual = 1; b1.sel = 2'd1;
        @(posedge clk); #1;
        n_cmp++; if (b0.ch_idx !== 2'd2) begin n_err++; $display("FAIL man_idx got %0d want 2", b0.ch_idx); end
        n_cmp++; if (b0.ch_onehot !== 4'b0100) begin n_err++; $display("FAIL man_onehot got %b want 0100", b0.ch_onehot); end
        n_cmp++; if (b0.dout !== 4'h3) begin n_err++; $display("FAIL man_dout got %h want 3", b0.dout); end
        n_cmp++; if (b0.wrap !== 1'b0) begin n_err++; $display("FAIL man_wrap got %b want 0", b0.wrap); end
        n_cmp++; if (b1.ch_idx !== 2'd1) begin n_err++; $display("FAIL man3_idx got %0d want 1", b1.ch_idx); end
        @(negedge clk);
        b0.din = 16'h4A21;
        b1.sel = 2'd3;
        n_cmp++; if (b0.dout !== 4'h3) begin n_err++; $display("FAIL latency_pre got %h want 3", b0.dout); end
        @(posedge clk); #1;
        n_cmp++; if (b0.dout !== 4'hA) begin n_err++; $display("FAIL latency_post got %h want a", b0.dout); end
        n_cmp++; if (b1.ch_idx !== 2'd1) begin n_err++; $display("FAIL man3_hold_idx got %0d want 1", b1.ch_idx); end
        n_cmp++; if (b1.ch_onehot !== 3'b010) begin n_err++; $display("FAIL man3_hold_onehot got %b want 010", b1.ch_onehot); end
        n_cmp++; if (b1.dout !== 4'h2) begin n_err++; $display("FAIL man3_hold_dout got %h want 2", b1.dout); end
        @(negedge clk) b0.manual = 0;
        for (int j = 1; j <= 4; j++) begin
            logic [1:0] ei;
            logic [3:0] ed;
            @(posedge clk); #1;
            ei = (j == 4) ? 2'd3 : 2'd2;
            ed = m_dout(int'(ei), j % 4, 16'h4A21);
            n_cmp++; if (b0.ch_idx !== ei) begin n_err++; $display("FAIL unman_idx j=%0d got %0d want %0d", j, b0.ch_idx, ei); end
            n_cmp++; if (b0.dout !== ed) begin n_err++; $display("FAIL unman_dout j=%0d got %h want %h", j, b0.dout, ed); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_cmp++; if (b0.ch_idx !== 2'd0) begin n_err++; $display("FAIL areset_idx got %0d want 0", b0.ch_idx); end
        n_cmp++; if (b0.ch_onehot !== 4'b0001) begin n_err++; $display("FAIL areset_onehot got %b want 0001", b0.ch_onehot); end
        n_cmp++; if (b0.dout !== 4'h0) begin n_err++; $display("FAIL areset_dout got %h want 0", b0.dout); end
        n_cmp++; if (b0.wrap !== 1'b0) begin n_err++; $display("FAIL areset_wrap got %b want 0", b0.wrap); end
        @(negedge clk) rst_n = 1;
        for (int j = 1; j <= 4; j++) begin
            logic [1:0] ei;
            logic [3:0] ed, eo;
            @(posedge clk); #1;
            ei = (j == 4) ? 2'd1 : 2'd0;
            ed = m_dout(int'(ei), j % 4, 16'h4A21);
            eo = m_oh(int'(ei), j % 4);
            n_cmp++; if (b0.ch_idx !== ei) begin n_err++; $display("FAIL arel_idx j=%0d got %0d want %0d", j, b0.ch_idx, ei); end
            n_cmp++; if (b0.dout !== ed) begin n_err++; $display("FAIL arel_dout j=%0d got %h want %h", j, b0.dout, ed); end
            n_cmp++; if (b0.ch_onehot !== eo) begin n_err++; $display("FAIL arel_onehot j=%0d got %b want %b", j, b0.ch_onehot, eo); end
        end
    endtask

    task automatic test_blank();
        int zeros, want;
        zeros = 0;
`ifdef MUX_SCAN_BLANK_EN
        want = 2;
`else
        want = 0;
`endif
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (b0.ch_onehot == 4'b0000 && b0.dout == 4'h0) zeros++;
        end
        n_cmp++; if (zeros !== want) begin n_err++; $display("FAIL blank_count got %0d want %0d", zeros, want); end
    endtask

    task automatic test_div1();
        @(negedge clk) b2.en = 1;
        for (int k = 1; k <= 6; k++) begin
            logic ei, ew;
            logic [3:0] ed;
            @(posedge clk); #1;
            ei = 1'(k % 2);
            ew = (k % 2) == 0;
            ed = ei ? 4'h2 : 4'h1;
            n_cmp++; if (b2.ch_idx !== ei) begin n_err++; $display("FAIL div1_idx k=%0d got %0d want %0d", k, b2.ch_idx, ei); end
            n_cmp++; if (b2.wrap !== ew) begin n_err++; $display("FAIL div1_wrap k=%0d got %b want %b", k, b2.wrap, ew); end
            n_cmp++; if (b2.dout !== ed) begin n_err++; $display("FAIL div1_dout k=%0d got %h want %h", k, b2.dout, ed); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hold();
        test_manual();
        test_async_reset();
        test_blank();
`ifndef MUX_SCAN_BLANK_EN
        test_div1();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the bit width of each data channel (>=1).
REQ-002 The module SHALL have parameter CHANNELS, default 4, meaning the number of input channels (>=2).
REQ-003 The module SHALL have parameter DIV, default 4, meaning clock cycles per channel slot (>=1; >=2 when MUX_SCAN_BLANK_EN is defined).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port en, input, 1 bit: auto-scan advance enable.
REQ-007 The module SHALL have port manual, input, 1 bit: 1 selects channel from sel; 0 selects auto-scan.
REQ-008 The module SHALL have port sel, input, $clog2(CHANNELS) bits: the manual channel index.
REQ-009 The module SHALL have port din, input, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The module SHALL have port dout, output, WIDTH bits: the registered selected channel data.
REQ-011 The module SHALL have port ch_onehot, output, CHANNELS bits: the registered one-hot active channel (bit k is active for channel k).
REQ-012 The module SHALL have port ch_idx, output, $clog2(CHANNELS) bits: the registered active channel index.
REQ-013 The module SHALL have port wrap, output, 1 bit: a one-cycle pulse when the scan wraps from CHANNELS-1 to 0.

Function
REQ-014 The module SHALL use a prescaler counting 0..DIV-1 while en=1 and manual=0, wrapping to 0 after DIV-1.
REQ-015 The module SHALL advance ch_idx by 1 on the edge where the prescaler equals DIV-1, provided en=1 and manual=0.
REQ-016 The module SHALL wrap ch_idx from CHANNELS-1 to 0 on advance and SHALL assert wrap for exactly the following cycle.
REQ-017 The module SHALL hold both the prescaler and ch_idx when en=0 and manual=0; wrap SHALL be 0 in that case.
REQ-018 The module SHALL set ch_idx to sel on each edge when manual=1 and sel<CHANNELS; with sel>=CHANNELS, ch_idx SHALL hold.
REQ-019 The module SHALL clear the prescaler to 0 on each edge when manual=1, and wrap SHALL never assert while manual=1.
REQ-020 The module SHALL resume auto-scan from the current ch_idx with the prescaler at 0 when manual returns to 0.
REQ-021 The module SHALL register dout from the din slice of the next ch_idx value on every edge, so dout, ch_onehot and ch_idx always refer to the same channel.
REQ-022 The module SHALL have a latency of exactly one clock from a din change to dout; dout SHALL track din on every edge regardless of en.
REQ-023 The module SHALL keep ch_onehot equal to the one-hot decode of ch_idx at all times, except during blanking per REQ-027.
REQ-024 The module SHALL tie the prescaler to 0 when DIV=1, so the channel advances every enabled cycle.

Reset
REQ-025 The module SHALL, while rst_n=0, immediately force prescaler=0, ch_idx=0, ch_onehot=1 (channel 0), dout=0 and wrap=0, independent of clk.
REQ-026 The module SHALL, after rst_n deasserts mid-scan, start from channel 0 with the prescaler at 0; the first advance SHALL occur DIV enabled cycles later.

Configuration
REQ-027 The module SHALL, when macro MUX_SCAN_BLANK_EN is defined, drive ch_onehot=0 and dout=0 during every auto-scan cycle where the prescaler equals 0 (anti-ghosting blank), while ch_idx updates normally.
REQ-028 The module SHALL, when MUX_SCAN_BLANK_EN is undefined, never blank; ch_onehot SHALL always be one-hot.
REQ-029 The module SHALL never blank in manual mode, regardless of MUX_SCAN_BLANK_EN.

Verification
REQ-030 The bench SHALL cover reset and scan: WIDTH=4, CHANNELS=4, DIV=4, din=0x4321, en=1 -> ch_idx sequence 0,1,2,3,0 every 4 cycles, dout=1,2,3,4,1, and wrap pulses once per 16 cycles.
REQ-031 The bench SHALL cover hold: deassert en for 10 cycles mid-slot -> ch_idx, dout and prescaler are frozen, and the slot completes after the remaining cycles once en=1.
REQ-032 The bench SHALL cover manual mode: manual=1, sel=2 -> next edge gives ch_idx=2, ch_onehot=0100, dout=din[11:8]; with CHANNELS=3 and sel=3, ch_idx holds.
REQ-033 The bench SHALL cover asynchronous reset: assert rst_n=0 between edges at ch_idx=3 -> outputs go to reset values before the next edge; after release, the first advance occurs 4 cycles later.
REQ-034 The bench SHALL cover blanking: with MUX_SCAN_BLANK_EN defined and DIV=4 -> the first cycle of each slot has ch_onehot=0000 and dout=0, and the other 3 cycles show the channel; without the macro there are no zero cycles.
REQ-035 The bench SHALL cover DIV=1, CHANNELS=2: ch_idx toggles every cycle and wrap asserts every 2 cycles.
